powerup_scheduler: RTL and testbench
====================================

Name: powerup_scheduler

Overview:
- Sequences the single on-field power-up for Pong: waits out a cooldown, picks a random position and mode, pulses spawn to the power-up renderer, and detects when it is eaten.
- On capture, grants the effect (shrink/boost/idk/shield) to the player who last hit the ball for a fixed number of frames, then restarts the cooldown.
- Sits between the game-logic top level and the power-up and shield pixel blocks.
- All timing is counted in frame ticks (one pulse per vsync).

Parameters:
- COOLDOWN_FRAMES, 180: frames in IDLE before each spawn.
- EFFECT_FRAMES, 300: frames an effect stays granted.
- LIFETIME_FRAMES, 600: frames an uneaten power-up stays on field (used only with the optional feature).
- X_BASE, 11'd200: minimum spawn x.
- Y_BASE, 10'd100: minimum spawn y.
- X_BITS, 9: random x offset width; x range is X_BASE..X_BASE+2^X_BITS-1.
- Y_BITS, 8: random y offset width.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- hit  in  1  ball overlaps power-up box; level, sampled each clk
- last_player  in  1  0 = left paddle, 1 = right paddle, last to touch ball
- spawn  out  1  one-cycle pulse; randx/randy/mode valid this cycle
- eaten  out  1  one-cycle pulse on capture
- randx  out  11  spawn x, held until next spawn
- randy  out  10  spawn y, held until next spawn
- mode  out  2  00 SHRINK, 01 BOOST, 10 IDK, 11 SHIELD
- effect_left  out  1  effect granted to left player
- effect_right  out  1  effect granted to right player
- frames_left  out  10  remaining effect frames; 0 when no effect

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE; counter = COOLDOWN_FRAMES.
  - spawn, eaten, effect_left, effect_right = 0.
  - randx = X_BASE; randy = Y_BASE; mode = 00; frames_left = 0.
  - LFSR = LFSR_SEED.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11; advances every clk regardless of state.
- States:
  - IDLE: decrement counter on each frame_tick. When a tick arrives with counter==1 (or counter==0), go to SPAWN.
  - SPAWN (exactly 1 cycle):
    - randx <= X_BASE + lfsr[X_BITS-1:0], zero-extended to 11 bits.
    - randy <= Y_BASE + lfsr[X_BITS+Y_BITS-1:X_BITS], zero-extended to 10 bits.
    - mode <= lfsr[15:14].
    - Registered spawn pulse is high for one cycle, aligned with the new coordinates.
    - Go to FIELD.
  - FIELD: on hit==1, go to GRANT. frame_tick has no effect (unless the optional feature is enabled).
  - GRANT (exactly 1 cycle):
    - eaten = 1.
    - effect_left = ~last_player; effect_right = last_player.
    - frames_left = EFFECT_FRAMES; go to EFFECT.
  - EFFECT:
    - Decrement frames_left on each frame_tick.
    - On the tick that takes it from 1 to 0: clear both effect bits, reload counter = COOLDOWN_FRAMES, go to IDLE.
- Output latency: every output is registered, one clk after the triggering event.
- Boundary conditions:
  - hit asserted in IDLE, SPAWN or EFFECT is ignored. Only one capture per spawn.
  - hit and frame_tick in the same cycle in FIELD: hit wins.
  - last_player is sampled only in the GRANT transition cycle. Later changes do not move the effect.
  - Exactly one of effect_left/effect_right is set in EFFECT; never both.
  - COOLDOWN_FRAMES=0 or EFFECT_FRAMES=0 is treated as 1 (one-frame wait).
  - No counter ever wraps below 0.
  - Reset mid-EFFECT clears the effect immediately (asynchronous).
  - randx/randy/mode keep their last values outside SPAWN so the renderer can sample them at any time.

Optional Feature:
- Macro: POWERUP_FIELD_TIMEOUT_EN.
- Defined: FIELD loads a lifetime counter = LIFETIME_FRAMES on entry and decrements it on frame_tick. Reaching 0 without a hit:
  - pulses eaten for one cycle with both effect bits 0 (so the renderer clears the box);
  - reloads counter = COOLDOWN_FRAMES and returns to IDLE.
- Undefined: FIELD waits indefinitely for hit; the LIFETIME_FRAMES parameter is unused.

Test Plan:
- Reset, then COOLDOWN_FRAMES=3 and 3 frame_ticks -> spawn pulse 1 clk after the 3rd tick; randx in 200..711; randy in 100..355; spawn width exactly 1 clk.
- After spawn, hit=1 with last_player=1 -> eaten pulse 1 clk; effect_right=1, effect_left=0; frames_left=300; mode unchanged from spawn.
- In EFFECT with EFFECT_FRAMES=2, 2 frame_ticks -> effect_right falls 1 clk after the 2nd tick; frames_left=0; state IDLE; next spawn after 3 more ticks.
- hit held high through IDLE and EFFECT -> no eaten pulse outside FIELD. hit held high through FIELD entry -> exactly one eaten pulse per spawn.
- Assert reset asynchronously mid-EFFECT (between clk edges) -> effect_left/right, frames_left and spawn go to 0 immediately; randx=200, randy=100.
- With POWERUP_FIELD_TIMEOUT_EN and LIFETIME_FRAMES=4, no hit and 4 ticks -> eaten pulse with both effect bits 0, then return to IDLE. Without the macro, 1000 ticks -> still in FIELD, no eaten pulse.

Source files
------------

// File: rtl/powerup_scheduler.sv
// Power-up sequencer: cooldown, random spawn, capture, timed effect grant.
// Optional POWERUP_FIELD_TIMEOUT_EN retires an uneaten power-up after LIFETIME_FRAMES.
module powerup_scheduler #(
  parameter int unsigned COOLDOWN_FRAMES = 180,
  parameter int unsigned EFFECT_FRAMES   = 300,
  parameter int unsigned LIFETIME_FRAMES = 600,
  parameter logic [10:0] X_BASE          = 11'd200,
  parameter logic [9:0]  Y_BASE          = 10'd100,
  parameter int unsigned X_BITS          = 9,
  parameter int unsigned Y_BITS          = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        last_player,
  output logic        spawn,
  output logic        eaten,
  output logic [10:0] randx,
  output logic [9:0]  randy,
  output logic [1:0]  mode,
  output logic        effect_left,
  output logic        effect_right,
  output logic [9:0]  frames_left
);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FIELD,
    GRANT,
    EFFECT
  } state_e;

  localparam logic [15:0] CD_L =
    (COOLDOWN_FRAMES == 0) ? 16'd1 : 16'(COOLDOWN_FRAMES);
  localparam logic [9:0] EF_L =
    (EFFECT_FRAMES == 0) ? 10'd1 : 10'(EFFECT_FRAMES);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [31:0] rnd;
  logic [10:0] xoff;
  logic [9:0]  yoff;

  assign lfsr_d = {1'b0, lfsr_q[15:1]}
                ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Doubling the LFSR lets the y slice run past bit 15 by wrapping.
  assign rnd  = {lfsr_q, lfsr_q};
  assign xoff = 11'(rnd[X_BITS-1:0]);
  assign yoff = 10'(rnd[X_BITS+Y_BITS-1:X_BITS]);

`ifdef POWERUP_FIELD_TIMEOUT_EN
  localparam logic [15:0] LT_L =
    (LIFETIME_FRAMES == 0) ? 16'd1 : 16'(LIFETIME_FRAMES);
  logic unused_ok;
  assign unused_ok = ^rnd;
`else
  logic unused_ok;
  assign unused_ok = ^{rnd, 32'(LIFETIME_FRAMES)};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= CD_L;
      lfsr_q       <= LFSR_SEED;
      spawn        <= 1'b0;
      eaten        <= 1'b0;
      randx        <= X_BASE;
      randy        <= Y_BASE;
      mode         <= 2'b00;
      effect_left  <= 1'b0;
      effect_right <= 1'b0;
      frames_left  <= 10'd0;
    end else begin
      lfsr_q <= lfsr_d;
      spawn  <= 1'b0;
      eaten  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            if (cnt_q <= 16'd1) begin
              state_q <= SPAWN;
              spawn   <= 1'b1;
              randx   <= X_BASE + xoff;
              randy   <= Y_BASE + yoff;
              mode    <= lfsr_q[15:14];
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
        end
        SPAWN: begin
          state_q <= FIELD;
`ifdef POWERUP_FIELD_TIMEOUT_EN
          cnt_q   <= LT_L;
`endif
        end
        FIELD: begin
          if (hit) begin
            state_q      <= GRANT;
            eaten        <= 1'b1;
            effect_left  <= ~last_player;
            effect_right <= last_player;
            frames_left  <= EF_L;
          end
`ifdef POWERUP_FIELD_TIMEOUT_EN
          else if (frame_tick) begin
            if (cnt_q <= 16'd1) begin
              state_q <= IDLE;
              eaten   <= 1'b1;
              cnt_q   <= CD_L;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
`endif
        end
        GRANT: begin
          state_q <= EFFECT;
        end
        EFFECT: begin
          if (frame_tick) begin
            if (frames_left <= 10'd1) begin
              state_q      <= IDLE;
              frames_left  <= 10'd0;
              effect_left  <= 1'b0;
              effect_right <= 1'b0;
              cnt_q        <= CD_L;
            end else begin
              frames_left <= frames_left - 10'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Randomized bench for powerup_scheduler against a phase-level reference model.
// Honours POWERUP_FIELD_TIMEOUT_EN when the same macro is defined for the build.
module tb_powerup_scheduler;

  localparam int CD = 3;
  localparam int EF = 5;
  localparam int LT = 4;

  localparam int P_IDLE   = 0;
  localparam int P_SPAWN  = 1;
  localparam int P_FIELD  = 2;
  localparam int P_GRANT  = 3;
  localparam int P_EFFECT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        hit;
  logic        last_player;
  logic        spawn;
  logic        eaten;
  logic [10:0] randx;
  logic [9:0]  randy;
  logic [1:0]  mode;
  logic        effect_left;
  logic        effect_right;
  logic [9:0]  frames_left;

  powerup_scheduler #(
    .COOLDOWN_FRAMES(CD),
    .EFFECT_FRAMES(EF),
    .LIFETIME_FRAMES(LT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .hit(hit),
    .last_player(last_player),
    .spawn(spawn),
    .eaten(eaten),
    .randx(randx),
    .randy(randy),
    .mode(mode),
    .effect_left(effect_left),
    .effect_right(effect_right),
    .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int          ph;
  int          idle_ticks;
  int          life_ticks;
  int          m_frames;
  logic [15:0] m_lfsr;
  int          m_spawn, m_eaten, m_x, m_y, m_mode, m_l, m_r;

  function automatic logic [15:0] next_lfsr(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    idle_ticks = 0;
    life_ticks = 0;
    m_frames = 0;
    m_lfsr = 16'hACE1;
    m_spawn = 0;
    m_eaten = 0;
    m_x = 200;
    m_y = 100;
    m_mode = 0;
    m_l = 0;
    m_r = 0;
  endtask

  task automatic model_step();
    int l;
    l = int'(m_lfsr);
    m_lfsr = next_lfsr(m_lfsr);
    m_spawn = 0;
    m_eaten = 0;
    case (ph)
      P_IDLE: if (frame_tick) begin
        idle_ticks++;
        if (idle_ticks >= CD) begin
          m_spawn = 1;
          m_x = 200 + (l % 512);
          m_y = 100 + ((l >> 9) | ((l & 1) << 7));
          m_mode = l / 16384;
          ph = P_SPAWN;
        end
      end
      P_SPAWN: begin
        life_ticks = 0;
        ph = P_FIELD;
      end
      P_FIELD: begin
        if (hit) begin
          m_eaten = 1;
          m_l = last_player ? 0 : 1;
          m_r = last_player ? 1 : 0;
          m_frames = EF;
          ph = P_GRANT;
        end
`ifdef POWERUP_FIELD_TIMEOUT_EN
        else if (frame_tick) begin
          life_ticks++;
          if (life_ticks >= LT) begin
            m_eaten = 1;
            idle_ticks = 0;
            ph = P_IDLE;
          end
        end
`endif
      end
      P_GRANT: ph = P_EFFECT;
      default: if (frame_tick) begin
        m_frames--;
        if (m_frames == 0) begin
          m_l = 0;
          m_r = 0;
          idle_ticks = 0;
          ph = P_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("spawn", 32'(spawn), m_spawn);
    check("eaten", 32'(eaten), m_eaten);
    check("randx", 32'(randx), m_x);
    check("randy", 32'(randy), m_y);
    check("mode", 32'(mode), m_mode);
    check("eff_l", 32'(effect_left), m_l);
    check("eff_r", 32'(effect_right), m_r);
    check("frames", 32'(frames_left), m_frames);
    check("eff_excl", 32'(effect_left & effect_right), 0);
    check("x_rng", 32'(randx >= 200 && randx <= 711), 1);
    check("y_rng", 32'(randy >= 100 && randy <= 355), 1);
  endtask

  task automatic cyc(input logic t, input logic h, input logic p);
    frame_tick = t;
    hit = h;
    last_player = p;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    hit = 1'b0;
    last_player = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Directed: three ticks to spawn, then a right-player capture.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("spawn_3rd", 32'(spawn), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("spawn_width", 32'(spawn), 0);
    cyc(1'b0, 1'b1, 1'b1);
    check("eaten_dir", 32'(eaten), 1);
    check("right_dir", 32'(effect_right), 1);
    check("frames_dir", 32'(frames_left), EF);
    for (int i = 0; i < EF + 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("eff_done", 32'(frames_left), 0);

    // hit held high everywhere, last_player toggling.
    for (int i = 0; i < 120; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of an effect.
    for (int i = 0; i < 200 && ph != P_EFFECT; i++) begin
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    end
    check("reach_eff", 32'(ph == P_EFFECT), 1);
    cyc(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_l", 32'(effect_left), 0);
    check("rst_r", 32'(effect_right), 0);
    check("rst_frames", 32'(frames_left), 0);
    check("rst_spawn", 32'(spawn), 0);
    check("rst_x", 32'(randx), 200);
    check("rst_y", 32'(randy), 100);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Park in FIELD and let 1000 ticks pass without a hit.
    for (int i = 0; i < 50 && ph != P_FIELD; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
    end
    check("reach_field", 32'(ph == P_FIELD), 1);
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
